// File: rtl/tli4970_multi_spi_control_if.sv
// Bus between the TLI4970 polling controller and the SPI master / sensor-result consumers.
// The controller side uses the slave modport. The SPI-master and test side uses the master modport.
interface tli4970_multi_spi_control_if #(
  parameter int NUM_SENSORS = 4,
  parameter int SEL_W       = 3
);
  // Handshake: wren is a one-cycle request to load the tx word; the SPI master answers
  // with a write_ack rising edge. di_req level asks for the next word. A data_read_valid
  // falling edge marks data_read as a finished rx word. sample_valid[k] is a one-cycle
  // strobe for the slice of sensor k in current/status_flag/parity_err.
  logic                     start;
  logic                     continuous;
  logic                     di_req;
  logic                     write_ack;
  logic                     data_read_valid;
  logic [15:0]              data_read;
  logic                     ss_n;
  logic                     wren;
  logic [SEL_W-1:0]         sensor_sel;
  logic                     spi_done;
  logic [16*NUM_SENSORS-1:0] current;
  logic [NUM_SENSORS-1:0]   status_flag;
  logic [NUM_SENSORS-1:0]   parity_err;
  logic [NUM_SENSORS-1:0]   sample_valid;

  modport master (
    output start, continuous, di_req, write_ack, data_read_valid, data_read, ss_n,
    input  wren, sensor_sel, spi_done, current, status_flag, parity_err, sample_valid
  );

  modport slave (
    input  start, continuous, di_req, write_ack, data_read_valid, data_read, ss_n,
    output wren, sensor_sel, spi_done, current, status_flag, parity_err, sample_valid
  );
endinterface

// File: rtl/tli4970_multi_spi_control.sv
// Round-robin poller for several TLI4970 current sensors sharing one SPI master.
// Sends one or more 0x0000 words per frame and decodes the last rx word of each frame.
module tli4970_multi_spi_control #(
  parameter int NUM_SENSORS     = 4,
  parameter int WORDS_PER_FRAME = 1,
  parameter int DELAY_CYCLES    = 64,
  parameter int SEL_W           = 3
) (
  input  logic                              clock_i,
  input  logic                              reset_n_i,
  tli4970_multi_spi_control_if.slave        bus,
  output logic [2:0]                        state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DELAY    = 3'd1,
    S_WRITE    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_WAIT_RX  = 3'd4,
    S_NEXT     = 3'd5
  } state_e;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SENSORS - 1);
  localparam logic [2:0]       WPF      = 3'(WORDS_PER_FRAME);
  localparam logic [7:0]       DLY      = 8'(DELAY_CYCLES);

  state_e                    state_q;
  logic [7:0]                dly_q;
  logic [2:0]                word_q;
  logic [2:0]                rx_q;
  logic                      need_di_q;
  logic [SEL_W-1:0]          sel_q;
  logic                      wren_q;
  logic                      done_q;
  logic                      ack_prev_q;
  logic                      drv_prev_q;
  logic [16*NUM_SENSORS-1:0] current_q;
  logic [NUM_SENSORS-1:0]    status_q;
  logic [NUM_SENSORS-1:0]    perr_q;
  logic [NUM_SENSORS-1:0]    sv_q;

  logic        ack_rise;
  logic        rx_fall;
  logic        rx_take;
  logic        rx_last;
  logic        parity_bad;
  logic [15:0] cur_d;

  assign ack_rise   = bus.write_ack & ~ack_prev_q;
  assign rx_fall    = ~bus.data_read_valid & drv_prev_q;
  // rx words are accepted only once the frame's tx exchange has started
  assign rx_take    = rx_fall && (state_q == S_WAIT_ACK || state_q == S_WAIT_RX) && (rx_q < WPF);
  assign rx_last    = rx_take && (rx_q == WPF - 3'd1);
  assign parity_bad = ^bus.data_read;
  assign cur_d      = {3'b000, bus.data_read[12:0]} - 16'd4096;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      dly_q      <= '0;
      word_q     <= '0;
      rx_q       <= '0;
      need_di_q  <= 1'b0;
      sel_q      <= '0;
      wren_q     <= 1'b0;
      done_q     <= 1'b1;
      ack_prev_q <= 1'b0;
      drv_prev_q <= 1'b0;
      current_q  <= '0;
      status_q   <= '0;
      perr_q     <= '0;
      sv_q       <= '0;
    end else begin
      ack_prev_q <= bus.write_ack;
      drv_prev_q <= bus.data_read_valid;
      sv_q       <= '0;
      wren_q     <= 1'b0;

      if (rx_take) rx_q <= rx_q + 3'd1;

      if (rx_last) begin
        for (int k = 0; k < NUM_SENSORS; k++) begin
          if (sel_q == SEL_W'(k)) begin
            sv_q[k] <= 1'b1;
            if (parity_bad) begin
              perr_q[k] <= 1'b1;
            end else if (bus.data_read[15]) begin
              status_q[k] <= 1'b1;
              perr_q[k]   <= 1'b0;
            end else begin
              current_q[16*k +: 16] <= cur_d;
              status_q[k]           <= 1'b0;
              perr_q[k]             <= 1'b0;
            end
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          if (bus.start && bus.ss_n) begin
            sel_q   <= '0;
            word_q  <= '0;
            rx_q    <= '0;
            done_q  <= 1'b0;
            dly_q   <= DLY;
            state_q <= S_DELAY;
          end
        end
        S_DELAY: begin
          if (dly_q == 8'd0) begin
            wren_q  <= 1'b1;
            state_q <= S_WRITE;
          end else begin
            dly_q <= dly_q - 8'd1;
          end
        end
        S_WRITE: state_q <= S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (ack_rise && !need_di_q) begin
            word_q <= word_q + 3'd1;
            if (word_q + 3'd1 < WPF) need_di_q <= 1'b1;
            else                     state_q   <= S_WAIT_RX;
          end else if (need_di_q && bus.di_req) begin
            need_di_q <= 1'b0;
            dly_q     <= DLY;
            state_q   <= S_DELAY;
          end
        end
        S_WAIT_RX: begin
          if (rx_q == WPF && bus.ss_n) state_q <= S_NEXT;
        end
        S_NEXT: begin
          word_q    <= '0;
          rx_q      <= '0;
          need_di_q <= 1'b0;
          dly_q     <= DLY;
          if (sel_q < LAST_SEL) begin
            sel_q   <= sel_q + SEL_W'(1);
            state_q <= S_DELAY;
          end else begin
            sel_q <= '0;
            if (bus.continuous) begin
              state_q <= S_DELAY;
            end else begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.wren         = wren_q;
  assign bus.sensor_sel   = sel_q;
  assign bus.spi_done     = done_q;
  assign bus.current      = current_q;
  assign bus.status_flag  = status_q;
  assign bus.parity_err   = perr_q;
  assign bus.sample_valid = sv_q;
  assign state_o          = state_q;

endmodule
